// File: rtl/instruction_mem.sv
// Writable instruction memory with a registered fetch port, a stall/hold
// handshake, a program-load write port and an optional post-reset NOP fill.
module instruction_mem #(
    parameter int unsigned     W             = 9,
    parameter int unsigned     D             = 12,
    parameter bit              FILL_ON_RESET = 1'b1,
    parameter logic [W-1:0]    NOP_CODE      = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fetch_req,
    input  logic [D-1:0] fetch_addr,
    input  logic         stall,
    output logic         fetch_valid,
    output logic [W-1:0] machine_code,
    input  logic         ld_en,
    input  logic [D-1:0] ld_addr,
    input  logic [W-1:0] ld_data,
    output logic         ld_drop,
    output logic         ready
);

    localparam int unsigned DEPTH = 2 ** D;
    localparam logic [D-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_e;

    localparam state_e RST_STATE = FILL_ON_RESET ? S_FILL : S_RUN;

    state_e       state_q, state_d;
    logic [D-1:0] fill_ptr_q, fill_ptr_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [W-1:0] machine_code_q, machine_code_d;
    logic         ld_drop_q, ld_drop_d;

    logic [W-1:0] mem_q [DEPTH];
    logic         mem_we;
    logic [D-1:0] mem_waddr;
    logic [W-1:0] mem_wdata;

    // Next-state, write-port steering and fetch-register logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        fill_ptr_d     = fill_ptr_q;
        fetch_valid_d  = fetch_valid_q;
        machine_code_d = machine_code_q;
        ld_drop_d      = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = ld_addr;
        mem_wdata      = ld_data;

        if (state_q == S_FILL) begin
            // The fill owns the write port; loads are dropped and reported.
            mem_we        = 1'b1;
            mem_waddr     = fill_ptr_q;
            mem_wdata     = NOP_CODE;
            ld_drop_d     = ld_en;
            fetch_valid_d = 1'b0;
            // Compare before increment so the pointer never wraps into a second pass.
            if (fill_ptr_q == LAST_ADDR) begin
                state_d = S_RUN;
            end else begin
                fill_ptr_d = fill_ptr_q + D'(1);
            end
        end else begin
            mem_we = ld_en;
            // While stalled the output pair and the request inputs are frozen.
            if (!stall) begin
                if (fetch_req) begin
                    fetch_valid_d  = 1'b1;
                    // Read of the pre-edge array gives old data on a same-address load.
                    machine_code_d = mem_q[fetch_addr];
                end else begin
                    fetch_valid_d  = 1'b0;
                end
            end
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q        <= RST_STATE;
            fill_ptr_q     <= '0;
            fetch_valid_q  <= 1'b0;
            machine_code_q <= '0;
            ld_drop_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_ptr_q     <= fill_ptr_d;
            fetch_valid_q  <= fetch_valid_d;
            machine_code_q <= machine_code_d;
            ld_drop_q      <= ld_drop_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM; the fill sequence initialises it instead.
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign machine_code = machine_code_q;
    assign ld_drop      = ld_drop_q;
    assign ready        = (state_q == S_RUN);

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: a filling instance (D=4, NOP 9'h1FE)
// checked every cycle against a scoreboard, plus a no-fill instance.
module tb_instruction_mem;

    localparam int unsigned W     = 9;
    localparam int unsigned D     = 4;
    localparam int          DEPTH = 16;
    localparam logic [W-1:0] NOP  = 9'h1FE;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         fetch_req, stall, ld_en;
    logic [D-1:0] fetch_addr, ld_addr;
    logic [W-1:0] ld_data;
    logic         fetch_valid, ld_drop, ready;
    logic [W-1:0] machine_code;

    logic         f0_req, f0_stall, f0_ld_en;
    logic [D-1:0] f0_addr, f0_ld_addr;
    logic [W-1:0] f0_ld_data;
    logic         f0_valid, f0_drop, f0_ready;
    logic [W-1:0] f0_code;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference model state.
    logic [W-1:0] model_mem [DEPTH];
    logic [W-1:0] sb_q [$];
    int           fill_cnt;
    logic         exp_valid;
    logic [W-1:0] exp_code;

    instruction_mem #(.W(W), .D(D), .FILL_ON_RESET(1'b1), .NOP_CODE(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
        .fetch_valid(fetch_valid), .machine_code(machine_code),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_drop(ld_drop), .ready(ready)
    );

    instruction_mem #(.W(W), .D(D), .FILL_ON_RESET(1'b0), .NOP_CODE(NOP)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(f0_req), .fetch_addr(f0_addr), .stall(f0_stall),
        .fetch_valid(f0_valid), .machine_code(f0_code),
        .ld_en(f0_ld_en), .ld_addr(f0_ld_addr), .ld_data(f0_ld_data),
        .ld_drop(f0_drop), .ready(f0_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus on the filling instance, then compare all outputs.
    task automatic cycle(input logic req, input logic [D-1:0] addr, input logic stl,
                         input logic ld, input logic [D-1:0] la, input logic [W-1:0] ldd);
        logic run_m;
        @(negedge clk);
        fetch_req  = req;
        fetch_addr = addr;
        stall      = stl;
        ld_en      = ld;
        ld_addr    = la;
        ld_data    = ldd;
        run_m = (fill_cnt == DEPTH);
        if (run_m && req && !stl) sb_q.push_back(model_mem[addr]);
        @(posedge clk);
        #1;
        if (!run_m) begin
            model_mem[fill_cnt] = NOP;
            fill_cnt++;
            exp_valid = 1'b0;
        end else begin
            if (ld) model_mem[la] = ldd;
            if (!stl) begin
                if (req && sb_q.size() > 0) begin
                    exp_valid = 1'b1;
                    exp_code  = sb_q.pop_front();
                end else begin
                    exp_valid = 1'b0;
                end
            end
        end
        check("ready", ready, fill_cnt == DEPTH);
        check("fetch_valid", fetch_valid, exp_valid);
        check("machine_code", machine_code, exp_code);
        check("ld_drop", ld_drop, !run_m && ld);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Assert reset mid-cycle, verify the asynchronous clear, release after a posedge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        stall     = 1'b0;
        ld_en     = 1'b0;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_machine_code", machine_code, 9'h000);
        check("rst_ld_drop", ld_drop, 1'b0);
        check("rst_ready_nofill", f0_ready, 1'b1);
        exp_valid = 1'b0;
        exp_code  = '0;
        fill_cnt  = 0;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        stall      = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        f0_req     = 1'b0;
        f0_addr    = '0;
        f0_stall   = 1'b0;
        f0_ld_en   = 1'b0;
        f0_ld_addr = '0;
        f0_ld_data = '0;
        fill_cnt   = 0;
        exp_valid  = 1'b0;
        exp_code   = '0;

        apply_reset();

        // No-fill instance: fetch and load on the very first edge, then read back the load.
        f0_req     = 1'b1;
        f0_addr    = 4'd1;
        f0_ld_en   = 1'b1;
        f0_ld_addr = 4'd1;
        f0_ld_data = 9'h123;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i == 0) begin
                check("nofill_first_valid", f0_valid, 1'b1);
                check("nofill_ready", f0_ready, 1'b1);
                f0_ld_en = 1'b0;
            end else if (i == 1) begin
                check("nofill_load_readback", f0_code, 9'h123);
                check("nofill_valid2", f0_valid, 1'b1);
                f0_req = 1'b0;
            end
        end

        // Reset mid-fill (fill cycle 8), then a complete fill with a load at fill cycle 3.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b0, i == 3, 4'd2, 9'h055);
        end

        // Back-to-back fetch of every word: all NOP, including the dropped-load address.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, D'(i), 1'b0, 1'b0, '0, '0);
        end
        idle();

        // Load then fetch.
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd3, 9'h07E);
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd4, 9'h0BE);
        cycle(1'b1, 4'd3, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 4'd4, 1'b0, 1'b0, '0, '0);
        idle();

        // Stall hold: output frozen for three cycles while the address moves.
        cycle(1'b1, 4'd3, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd4, 1'b1, 1'b0, '0, '0);
            check("stall_hold_code", machine_code, 9'h07E);
        end
        cycle(1'b1, 4'd4, 1'b0, 1'b0, '0, '0);
        check("stall_release_code", machine_code, 9'h0BE);
        idle();

        // Read-during-write returns old data; next fetch sees the new word.
        cycle(1'b0, '0, 1'b0, 1'b1, 4'd5, 9'h001);
        cycle(1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 9'h1AA);
        check("rdw_old_data", machine_code, 9'h001);
        cycle(1'b1, 4'd5, 1'b0, 1'b0, '0, '0);
        check("rdw_new_data", machine_code, 9'h1AA);
        idle();

        // Mixed random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), D'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  D'($urandom_range(0, DEPTH - 1)), W'($urandom));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
